// File: rtl/sti_frame_receiver_if.sv
// Bundle of the serial-frame input, FIFO output port and status signals of sti_frame_receiver.
// The receiver uses the slave side; whatever feeds frames and drains the FIFO uses the master side.
interface sti_frame_receiver_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          si_data;
    logic          si_valid;
    logic          out_ready;
    logic          out_valid;
    logic [31:0]   out_data;
    logic [1:0]    out_len;
    logic          frm_err;
    logic          ovf;
    logic [CW-1:0] fifo_cnt;
    logic [7:0]    frame_cnt;

    modport master (
        output si_data, si_valid, out_ready,
        input  out_valid, out_data, out_len, frm_err, ovf, fifo_cnt, frame_cnt
    );

    modport slave (
        input  si_data, si_valid, out_ready,
        output out_valid, out_data, out_len, frm_err, ovf, fifo_cnt, frame_cnt
    );
endinterface

// File: rtl/sti_frame_receiver.sv
// Deserialises MSB-first serial frames of 8/16/24/32 bits into right-aligned words
// and queues them with a length code in a small valid/ready FIFO.
module sti_frame_receiver #(
    parameter int DEPTH = 4
) (
    input logic                 clk,
    input logic                 reset,
    sti_frame_receiver_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RECV    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]    r_state;
    logic [31:0]   r_shift;
    logic [5:0]    r_bitCnt;
    logic          r_frmErr;
    logic          r_ovf;
    logic [31:0]   r_memData [DEPTH];
    logic [1:0]    r_memLen  [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_frameCnt;

    logic          w_frameEnd;
    logic          w_goodLen;
    logic          w_badEnd;
    logic          w_push;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_write;
    logic [1:0]    w_len;

    // A frame ends on the first idle sample seen in RECV; only whole-byte lengths are kept.
    assign w_frameEnd = (r_state == S_RECV) && !bus.si_valid;
    assign w_goodLen  = (r_bitCnt[2:0] == 3'd0) && (r_bitCnt != 6'd0);
    assign w_len      = 2'(r_bitCnt[5:3] - 3'd1);
    assign w_push     = w_frameEnd && w_goodLen;
    assign w_badEnd   = (w_frameEnd && !w_goodLen) ||
                        ((r_state == S_DISCARD) && !bus.si_valid);

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = !w_empty && bus.out_ready;
    // A simultaneous pop frees the slot the new entry lands in, even when full.
    assign w_write = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_bitCnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.si_valid) begin
                        r_shift  <= {31'd0, bus.si_data};
                        r_bitCnt <= 6'd1;
                        r_state  <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (!bus.si_valid) begin
                        r_state <= S_IDLE;
                    end else if (r_bitCnt == 6'd32) begin
                        r_state <= S_DISCARD;
                    end else begin
                        r_shift  <= {r_shift[30:0], bus.si_data};
                        r_bitCnt <= r_bitCnt + 6'd1;
                    end
                end
                S_DISCARD: begin
                    if (!bus.si_valid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frmErr <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_frmErr <= w_badEnd;
            r_ovf    <= w_push && w_full && !w_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_memData[r_wrPtr] <= r_shift;
            r_memLen[r_wrPtr]  <= w_len;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_frameCnt <= '0;
        end else begin
            if (w_write) begin
                r_wrPtr    <= r_wrPtr + AW'(1);
                r_frameCnt <= r_frameCnt + 8'd1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage contents are undefined until written, so the head is masked while empty.
    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_empty ? 32'd0 : r_memData[r_rdPtr];
    assign bus.out_len   = w_empty ? 2'd0  : r_memLen[r_rdPtr];
    assign bus.frm_err   = r_frmErr;
    assign bus.ovf       = r_ovf;
    assign bus.fifo_cnt  = r_count;
    assign bus.frame_cnt = r_frameCnt;
endmodule

// File: tb/tb_sti_frame_receiver.sv
// Scoreboard bench for sti_frame_receiver: directed frames push expected entries,
// an independent monitor compares every FIFO pop and tallies error/overflow pulses.
module tb_sti_frame_receiver;
    logic clk;
    logic reset;

    sti_frame_receiver_if #(.DEPTH(4)) bus ();

    sti_frame_receiver #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int errCnt      = 0;
    int ovfCnt      = 0;
    int validCycles = 0;
    logic [33:0] sbQ[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives an n-bit frame MSB first, one bit per cycle, then leaves the line idle.
    task automatic applyStimulus(input logic [63:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.si_valid = 1'b1;
            bus.si_data  = bits[i];
            @(posedge clk); #1;
        end
        bus.si_valid = 1'b0;
        bus.si_data  = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: every accepted head entry must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.frm_err) errCnt++;
            if (bus.ovf) ovfCnt++;
            if (bus.out_valid) validCycles++;
            if (bus.out_valid && bus.out_ready) begin
                if (sbQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpectedPop: got 0x%08h len %0d, expected no entry", bus.out_data, bus.out_len);
                end else begin
                    logic [33:0] exp;
                    exp = sbQ.pop_front();
                    checkOutput("popData", bus.out_data, exp[31:0]);
                    checkOutput("popLen", 32'(bus.out_len), 32'(exp[33:32]));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int errSnap;
        int ovfSnap;
        int validSnap;

        reset         = 1'b1;
        bus.si_data   = 1'b0;
        bus.si_valid  = 1'b0;
        bus.out_ready = 1'b0;
        idleCycles(3);
        checkOutput("rstValid", 32'(bus.out_valid), 32'd0);
        checkOutput("rstData", bus.out_data, 32'd0);
        checkOutput("rstLen", 32'(bus.out_len), 32'd0);
        checkOutput("rstFifoCnt", 32'(bus.fifo_cnt), 32'd0);
        checkOutput("rstFrameCnt", 32'(bus.frame_cnt), 32'd0);
        checkOutput("rstErrOvf", 32'({bus.frm_err, bus.ovf}), 32'd0);
        reset = 1'b0;
        idleCycles(2);

        $display("[TB] 8-bit frame 0xA5 with latency check");
        sbQ.push_back({2'd0, 32'h000000A5});
        applyStimulus(64'hA5, 8);
        checkOutput("t1NotYetValid", 32'(bus.out_valid), 32'd0);
        idleCycles(1);
        checkOutput("t1Valid", 32'(bus.out_valid), 32'd1);
        checkOutput("t1HeadData", bus.out_data, 32'h000000A5);
        checkOutput("t1HeadLen", 32'(bus.out_len), 32'd0);
        checkOutput("t1FrameCnt", 32'(bus.frame_cnt), 32'd1);
        checkOutput("t1FifoCnt", 32'(bus.fifo_cnt), 32'd1);
        bus.out_ready = 1'b1;
        idleCycles(3);
        checkOutput("t1Drained", 32'(bus.fifo_cnt), 32'd0);

        $display("[TB] 32-bit frame 0xDEADBEEF with consumer ready");
        validSnap = validCycles;
        sbQ.push_back({2'd3, 32'hDEADBEEF});
        applyStimulus(64'hDEADBEEF, 32);
        idleCycles(4);
        checkOutput("t2ValidCycles", 32'(validCycles - validSnap), 32'd1);
        checkOutput("t2FifoCnt", 32'(bus.fifo_cnt), 32'd0);
        checkOutput("t2FrameCnt", 32'(bus.frame_cnt), 32'd2);

        $display("[TB] malformed 12-bit and 40-bit frames");
        errSnap = errCnt;
        applyStimulus(64'h0ABC, 12);
        idleCycles(3);
        checkOutput("t3Err12", 32'(errCnt - errSnap), 32'd1);
        applyStimulus(64'h12_3456_789A, 40);
        idleCycles(3);
        checkOutput("t3Err40", 32'(errCnt - errSnap), 32'd2);
        checkOutput("t3FrameCnt", 32'(bus.frame_cnt), 32'd2);
        checkOutput("t3FifoCnt", 32'(bus.fifo_cnt), 32'd0);

        $display("[TB] overflow with five 16-bit frames");
        bus.out_ready = 1'b0;
        errSnap = errCnt;
        ovfSnap = ovfCnt;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) sbQ.push_back({2'd1, 32'(k)});
            applyStimulus(64'(k), 16);
            idleCycles(1);
        end
        idleCycles(2);
        checkOutput("t4FifoCnt", 32'(bus.fifo_cnt), 32'd4);
        checkOutput("t4Ovf", 32'(ovfCnt - ovfSnap), 32'd1);
        checkOutput("t4FrameCnt", 32'(bus.frame_cnt), 32'd6);
        checkOutput("t4NoErr", 32'(errCnt - errSnap), 32'd0);
        bus.out_ready = 1'b1;
        idleCycles(6);
        checkOutput("t4Drained", 32'(bus.fifo_cnt), 32'd0);
        checkOutput("t4SbEmpty", 32'(sbQ.size()), 32'd0);

        $display("[TB] push and pop on the same edge while full");
        bus.out_ready = 1'b0;
        ovfSnap = ovfCnt;
        for (int k = 0; k < 4; k++) begin
            sbQ.push_back({2'd0, 32'h11 + 32'(k)});
            applyStimulus(64'h11 + 64'(k), 8);
            idleCycles(1);
        end
        checkOutput("t5Full", 32'(bus.fifo_cnt), 32'd4);
        sbQ.push_back({2'd0, 32'h15});
        applyStimulus(64'h15, 8);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        idleCycles(2);
        checkOutput("t5FifoCnt", 32'(bus.fifo_cnt), 32'd4);
        checkOutput("t5NoOvf", 32'(ovfCnt - ovfSnap), 32'd0);
        checkOutput("t5FrameCnt", 32'(bus.frame_cnt), 32'd11);
        bus.out_ready = 1'b1;
        idleCycles(6);
        checkOutput("t5Drained", 32'(bus.fifo_cnt), 32'd0);
        checkOutput("t5SbEmpty", 32'(sbQ.size()), 32'd0);

        $display("[TB] reset mid-frame with queued entries");
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(64'h21 + 64'(k), 8);
            idleCycles(1);
        end
        checkOutput("t6Queued", 32'(bus.fifo_cnt), 32'd2);
        errSnap = errCnt;
        ovfSnap = ovfCnt;
        for (int i = 0; i < 10; i++) begin
            bus.si_valid = 1'b1;
            bus.si_data  = (i % 2 == 0);
            if (i == 9) begin
                #2 reset = 1'b1;
                bus.si_valid = 1'b0;
                bus.si_data  = 1'b0;
            end
            @(posedge clk); #1;
        end
        sbQ.delete();
        idleCycles(2);
        checkOutput("t6RstValid", 32'(bus.out_valid), 32'd0);
        checkOutput("t6RstData", bus.out_data, 32'd0);
        checkOutput("t6RstFifoCnt", 32'(bus.fifo_cnt), 32'd0);
        checkOutput("t6RstFrameCnt", 32'(bus.frame_cnt), 32'd0);
        reset = 1'b0;
        idleCycles(3);
        checkOutput("t6NoPulses", 32'((errCnt - errSnap) + (ovfCnt - ovfSnap)), 32'd0);
        sbQ.push_back({2'd0, 32'h3C});
        applyStimulus(64'h3C, 8);
        idleCycles(1);
        checkOutput("t6NewData", bus.out_data, 32'h0000003C);
        checkOutput("t6NewFrameCnt", 32'(bus.frame_cnt), 32'd1);
        bus.out_ready = 1'b1;
        idleCycles(3);
        checkOutput("t6Drained", 32'(bus.fifo_cnt), 32'd0);
        checkOutput("t6SbEmpty", 32'(sbQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
